sevenseg_scan_mux: RTL and testbench

- Drives a 4-digit multiplexed seven-segment display from a 16-bit hex value.
- Sits directly downstream of the 100 MHz clock divider. It consumes the divider's 190 Hz output as a scan-rate strobe.
- All logic runs on clk_100M. The 190 Hz signal is treated as a data level and edge-detected; it is never used as a clock.
- Inserts a programmable anode blanking gap between digits to suppress ghosting. Supports leading-zero suppression.

---
 rtl/sevenseg_scan_mux.sv | 177 +++++++++++++++++
 tb/tb_sevenseg_scan_mux.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/sevenseg_scan_mux.sv
// +----------------------------------------------------------------------------+
// | sevenseg_scan_mux: 4-digit multiplexed seven-segment driver with anode     |
// | blanking gap, leading-zero suppression and frame-coherent input snapshot.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module sevenseg_scan_mux #(
  parameter int BLANK_CYCLES   = 1000,
  parameter bit AN_ACTIVE_LOW  = 1'b1,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic        clk_100M,
  input  logic        clr,
  input  logic        scan_clk,
  input  logic [15:0] value,
  input  logic [3:0]  dp_in,
  input  logic [3:0]  digit_en,
  input  logic        blank_lz,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [1:0]  digit_idx
);

  localparam logic [1:0]  S_IDLE    = 2'd0;
  localparam logic [1:0]  S_BLANK   = 2'd1;
  localparam logic [1:0]  S_DRIVE   = 2'd2;
  localparam logic [15:0] C_BLANK   = 16'(BLANK_CYCLES);
  localparam logic [3:0]  C_AN_OFF  = {4{AN_ACTIVE_LOW}};
  localparam logic [6:0]  C_SEG_OFF = {7{SEG_ACTIVE_LOW}};

  logic [1:0]  r_state, w_state_nxt;
  logic [15:0] r_cnt, w_cnt_nxt;
  logic [1:0]  r_idx, w_idx_nxt;
  logic        r_scan_d;
  logic [15:0] r_value, w_value_nxt;
  logic [3:0]  r_dp_in, w_dp_in_nxt;
  logic [3:0]  r_en, w_en_nxt;
  logic        r_lz, w_lz_nxt;
  logic [3:0]  r_an, w_an_nxt;
  logic [6:0]  r_seg, w_seg_nxt;
  logic        r_dp, w_dp_nxt;
  logic        w_scan_edge, w_snap;
  logic [3:0]  w_nib;
  logic [6:0]  w_seg_hi;
  logic        w_dark;

  assign w_scan_edge = scan_clk & ~r_scan_d;
  assign w_snap      = w_scan_edge & (r_idx == 2'd3);
  assign w_idx_nxt   = w_scan_edge ? r_idx + 2'd1 : r_idx;

  // Shadow copies refresh only when the scan wraps to digit 0, so a frame never tears.
  assign w_value_nxt = w_snap ? value    : r_value;
  assign w_dp_in_nxt = w_snap ? dp_in    : r_dp_in;
  assign w_en_nxt    = w_snap ? digit_en : r_en;
  assign w_lz_nxt    = w_snap ? blank_lz : r_lz;

  always_ff @(posedge clk_100M or posedge clr) begin
    if (clr) begin
      r_scan_d <= 1'b0;
      r_idx    <= 2'd3;
      r_value  <= 16'h0000;
      r_dp_in  <= 4'h0;
      r_en     <= 4'h0;
      r_lz     <= 1'b0;
    end else begin
      r_scan_d <= scan_clk;
      r_idx    <= w_idx_nxt;
      r_value  <= w_value_nxt;
      r_dp_in  <= w_dp_in_nxt;
      r_en     <= w_en_nxt;
      r_lz     <= w_lz_nxt;
    end
  end

  always_ff @(posedge clk_100M or posedge clr) begin
    if (clr) begin
      r_state <= S_IDLE;
      r_cnt   <= 16'h0000;
      r_an    <= C_AN_OFF;
      r_seg   <= C_SEG_OFF;
      r_dp    <= SEG_ACTIVE_LOW;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_an    <= w_an_nxt;
      r_seg   <= w_seg_nxt;
      r_dp    <= w_dp_nxt;
    end
  end

  // Counter reaches zero on the same edge that enters DRIVE, giving exactly
  // C_BLANK dark cycles after the strobe edge.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (w_scan_edge) begin
      if (C_BLANK == 16'd0) begin
        w_state_nxt = S_DRIVE;
        w_cnt_nxt   = 16'd0;
      end else begin
        w_state_nxt = S_BLANK;
        w_cnt_nxt   = C_BLANK;
      end
    end else if (r_state == S_BLANK) begin
      if (r_cnt <= 16'd1) begin
        w_state_nxt = S_DRIVE;
        w_cnt_nxt   = 16'd0;
      end else begin
        w_cnt_nxt = r_cnt - 16'd1;
      end
    end
  end

  always_comb begin
    w_nib  = 4'h0;
    w_dark = 1'b0;
    case (w_idx_nxt)
      2'd0: w_nib = w_value_nxt[3:0];
      2'd1: begin
        w_nib  = w_value_nxt[7:4];
        w_dark = (w_value_nxt[15:4] == 12'h000);
      end
      2'd2: begin
        w_nib  = w_value_nxt[11:8];
        w_dark = (w_value_nxt[15:8] == 8'h00);
      end
      default: begin
        w_nib  = w_value_nxt[15:12];
        w_dark = (w_value_nxt[15:12] == 4'h0);
      end
    endcase
    w_dark = w_dark & w_lz_nxt;
  end

  always_comb begin
    w_seg_hi = 7'h00;
    case (w_nib)
      4'h0: w_seg_hi = 7'h3F;
      4'h1: w_seg_hi = 7'h06;
      4'h2: w_seg_hi = 7'h5B;
      4'h3: w_seg_hi = 7'h4F;
      4'h4: w_seg_hi = 7'h66;
      4'h5: w_seg_hi = 7'h6D;
      4'h6: w_seg_hi = 7'h7D;
      4'h7: w_seg_hi = 7'h07;
      4'h8: w_seg_hi = 7'h7F;
      4'h9: w_seg_hi = 7'h6F;
      4'hA: w_seg_hi = 7'h77;
      4'hB: w_seg_hi = 7'h7C;
      4'hC: w_seg_hi = 7'h39;
      4'hD: w_seg_hi = 7'h5E;
      4'hE: w_seg_hi = 7'h79;
      default: w_seg_hi = 7'h71;
    endcase
  end

  always_comb begin
    w_an_nxt  = C_AN_OFF;
    w_seg_nxt = C_SEG_OFF;
    w_dp_nxt  = SEG_ACTIVE_LOW;
    if ((w_state_nxt == S_DRIVE) && w_en_nxt[w_idx_nxt]) begin
      w_an_nxt  = (4'b0001 << w_idx_nxt) ^ C_AN_OFF;
      w_seg_nxt = (w_dark ? 7'h00 : w_seg_hi) ^ C_SEG_OFF;
      w_dp_nxt  = w_dp_in_nxt[w_idx_nxt] ^ SEG_ACTIVE_LOW;
    end
  end

  assign an        = r_an;
  assign seg       = r_seg;
  assign dp        = r_dp;
  assign digit_idx = r_idx;

endmodule

`default_nettype wire

// File: tb/tb_sevenseg_scan_mux.sv
// +----------------------------------------------------------------------------+
// | tb_sevenseg_scan_mux: randomized self-checking bench, two blanking widths. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_sevenseg_scan_mux;

  logic        clk = 1'b0;
  logic        clr;
  logic        scan_clk;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic [3:0]  digit_en;
  logic        blank_lz;

  logic [3:0] an4, an10;
  logic [6:0] seg4, seg10;
  logic       dp4, dp10;
  logic [1:0] idx4, idx10;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: time since last strobe edge plus a frame snapshot.
  int  m_idx, m_since, s_value;
  bit  m_active, m_prev, s_lz;
  logic [3:0] s_dp, s_en;
  logic [6:0] seg_tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  always #5 clk = ~clk;

  sevenseg_scan_mux #(.BLANK_CYCLES(4), .AN_ACTIVE_LOW(1'b1), .SEG_ACTIVE_LOW(1'b1)) u_dut4 (
    .clk_100M(clk), .clr(clr), .scan_clk(scan_clk), .value(value), .dp_in(dp_in),
    .digit_en(digit_en), .blank_lz(blank_lz), .an(an4), .seg(seg4), .dp(dp4), .digit_idx(idx4));

  sevenseg_scan_mux #(.BLANK_CYCLES(10), .AN_ACTIVE_LOW(1'b1), .SEG_ACTIVE_LOW(1'b1)) u_dut10 (
    .clk_100M(clk), .clr(clr), .scan_clk(scan_clk), .value(value), .dp_in(dp_in),
    .digit_en(digit_en), .blank_lz(blank_lz), .an(an10), .seg(seg10), .dp(dp10), .digit_idx(idx10));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    else n_pass++;
  endtask

  task automatic model_reset();
    m_idx = 3; m_since = 0; m_active = 0; m_prev = 0;
    s_value = 0; s_lz = 0; s_dp = 4'h0; s_en = 4'h0;
  endtask

  task automatic model_step();
    bit rise;
    if (clr) begin
      model_reset();
      return;
    end
    rise   = scan_clk && !m_prev;
    m_prev = scan_clk;
    if (rise) begin
      if (m_idx == 3) begin
        s_value = int'(value); s_lz = blank_lz; s_dp = dp_in; s_en = digit_en;
      end
      m_idx    = (m_idx + 1) % 4;
      m_since  = 0;
      m_active = 1;
    end else if (m_since < 1000000) begin
      m_since++;
    end
  endtask

  task automatic expect_out(input int b, output logic [3:0] e_an, output logic [6:0] e_seg,
                            output logic e_dp);
    int  upper;
    bit  dark;
    e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
    if (m_active && m_since >= b && s_en[m_idx]) begin
      upper = s_value >> (4 * m_idx);
      dark  = s_lz && (m_idx > 0) && (upper == 0);
      e_an  = ~(4'(1 << m_idx));
      e_seg = ~(dark ? 7'h00 : seg_tbl[upper % 16]);
      e_dp  = ~s_dp[m_idx];
    end
  endtask

  task automatic compare_all();
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp;
    expect_out(4, e_an, e_seg, e_dp);
    chk("an_b4", an4, e_an);
    chk("seg_b4", seg4, e_seg);
    chk("dp_b4", dp4, e_dp);
    chk("idx_b4", idx4, m_idx);
    expect_out(10, e_an, e_seg, e_dp);
    chk("an_b10", an10, e_an);
    chk("seg_b10", seg10, e_seg);
    chk("dp_b10", dp10, e_dp);
    chk("idx_b10", idx10, m_idx);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic scan_cycle(input int hi, input int lo);
    scan_clk = 1'b1;
    repeat (hi) tick();
    scan_clk = 1'b0;
    repeat (lo) tick();
  endtask

  logic [3:0] exp_an_frame [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
  logic [6:0] exp_sg_frame [4] = '{7'h0E, 7'h08, 7'h24, 7'h79};

  initial begin
    int first;
    clr = 1'b1; scan_clk = 1'b0; value = 16'h0; dp_in = 4'h0; digit_en = 4'h0; blank_lz = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    compare_all();
    chk("rst_an", an10, 4'hF);
    chk("rst_seg", seg10, 7'h7F);
    chk("rst_idx", idx4, 2'd3);
    clr = 1'b0;
    repeat (1000) tick();

    // Frame of 12AF with explicit digit checks on the 4-cycle blanking instance.
    value = 16'h12AF; digit_en = 4'hF; dp_in = 4'h0; blank_lz = 1'b0;
    for (int k = 0; k < 4; k++) begin
      scan_clk = 1'b1;
      repeat (4) tick();
      chk("gap_an", an4, 4'hF);
      repeat (2) tick();
      chk("frame_an", an4, exp_an_frame[k]);
      chk("frame_seg", seg4, exp_sg_frame[k]);
      scan_clk = 1'b0;
      repeat (8) tick();
    end

    // Leading-zero suppression.
    value = 16'h0030; blank_lz = 1'b1; dp_in = 4'b1000;
    repeat (4) scan_cycle(8, 8);

    // Mid-frame change must not tear.
    value = 16'h1111; blank_lz = 1'b0; dp_in = 4'h0;
    repeat (3) scan_cycle(8, 8);
    value = 16'h2222;
    repeat (2) scan_cycle(8, 8);
    chk("tear_next_seg", seg10, 7'h24);

    // Second strobe two cycles into blanking.
    scan_clk = 1'b1; tick();
    scan_clk = 1'b0; tick();
    scan_clk = 1'b1; tick();
    first = -1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (first < 0 && an10 !== 4'hF) first = k;
    end
    chk("dbl_gap", first, 10);
    scan_clk = 1'b0;
    repeat (6) tick();

    // Reset asserted while digit 2 is driven.
    while (m_idx != 1) scan_cycle(8, 8);
    scan_cycle(14, 1);
    clr = 1'b1;
    #1;
    model_reset();
    compare_all();
    chk("clr_an_async", an10, 4'hF);
    @(negedge clk);
    tick();
    clr = 1'b0;
    repeat (3) tick();
    scan_cycle(14, 6);
    chk("post_clr_idx", idx10, 2'd0);

    for (int it = 0; it < 300; it++) begin
      if ($urandom_range(0, 2) == 0) value = 16'($urandom);
      if ($urandom_range(0, 3) == 0) dp_in = 4'($urandom);
      if ($urandom_range(0, 3) == 0) digit_en = 4'($urandom);
      if ($urandom_range(0, 3) == 0) blank_lz = 1'($urandom);
      if ($urandom_range(0, 4) == 0) value = 16'($urandom_range(0, 255));
      if ($urandom_range(0, 60) == 0) begin
        clr = 1'b1;
        model_reset();
        #1 compare_all();
        @(negedge clk);
        clr = 1'b0;
      end
      scan_cycle($urandom_range(1, 14), $urandom_range(1, 14));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
